// File: rtl/prim_boolfn_pkg.sv
// Shared types and the bitwise SHA round function used by prim_boolfn_pipe.
// Words are evaluated at MaxWidth bits; callers zero-extend and keep the low Width bits.
package prim_boolfn_pkg;

    typedef enum logic [1:0] {
        CH     = 2'b00,
        PARITY = 2'b01,
        MAJ    = 2'b10,
        RSVD   = 2'b11
    } boolfn_mode_e;

    localparam int unsigned MaxWidth = 64;
    typedef logic [MaxWidth-1:0] word_t;

    function automatic word_t boolfn_eval(input boolfn_mode_e mode, input word_t x,
                                          input word_t y, input word_t z);
        word_t res;
        case (mode)
            CH:      res = (x & y) ^ (~x & z);
            PARITY:  res = x ^ y ^ z;
            MAJ:     res = (x & y) ^ (x & z) ^ (y & z);
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic boolfn_is_rsvd(input boolfn_mode_e mode);
        return mode == RSVD;
    endfunction

endpackage

// File: rtl/prim_boolfn_stage.sv
// One elastic pipeline slice: holds {valid, payload} and loads whenever it is empty
// or its downstream neighbour takes the current item in the same cycle.
module prim_boolfn_stage #(
    parameter int unsigned PayloadW = 33
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [PayloadW-1:0] in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [PayloadW-1:0] out_data_o
);

    logic                valid_q, valid_d;
    logic [PayloadW-1:0] data_q, data_d;
    logic                load;

    assign load = ~valid_q | out_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = in_valid_i;
        end
        // Payload only captures real items so idle slices do not toggle.
        if (load && in_valid_i && !flush_i) begin
            data_d = in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready_o  = load;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/prim_boolfn_pipe.sv
// Selectable Ch/Parity/Maj of three words feeding a chain of elastic slices with
// flush and occupancy count. Width must not exceed prim_boolfn_pkg::MaxWidth.
module prim_boolfn_pipe
    import prim_boolfn_pkg::*;
#(
    parameter int unsigned Width  = 32,
    parameter int unsigned Stages = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [1:0]                   mode_i,
    input  logic [Width-1:0]             x_i,
    input  logic [Width-1:0]             y_i,
    input  logic [Width-1:0]             z_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [Width-1:0]             out_o,
    output logic                         err_o,
    output logic [$clog2(Stages+1)-1:0]  count_o
);

    localparam int unsigned CntW = $clog2(Stages + 1);

    word_t              x_ext, y_ext, z_ext, fn_res;
    logic               unused_fn_res;
    logic [Stages:0]    valid_c;
    logic [Stages:0]    ready_c;
    logic [Stages:0][Width:0] data_c;
    logic [CntW-1:0]    count_sum;

    always_comb begin
        x_ext = '0;
        y_ext = '0;
        z_ext = '0;
        x_ext[Width-1:0] = x_i;
        y_ext[Width-1:0] = y_i;
        z_ext[Width-1:0] = z_i;
        fn_res = boolfn_eval(boolfn_mode_e'(mode_i), x_ext, y_ext, z_ext);
    end

    // Bits above Width are always zero and intentionally dropped.
    assign unused_fn_res = ^fn_res;

    assign data_c[0]       = {boolfn_is_rsvd(boolfn_mode_e'(mode_i)), fn_res[Width-1:0]};
    assign valid_c[0]      = in_valid_i & ~flush_i;
    assign ready_c[Stages] = out_ready_i;
    assign in_ready_o      = ready_c[0] & ~flush_i;

    for (genvar gi = 0; gi < Stages; gi++) begin : g_stage
        prim_boolfn_stage #(
            .PayloadW (Width + 1)
        ) u_stage (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .flush_i     (flush_i),
            .in_valid_i  (valid_c[gi]),
            .in_ready_o  (ready_c[gi]),
            .in_data_i   (data_c[gi]),
            .out_valid_o (valid_c[gi+1]),
            .out_ready_i (ready_c[gi+1]),
            .out_data_o  (data_c[gi+1])
        );
    end

    always_comb begin
        count_sum = '0;
        for (int unsigned i = 1; i <= Stages; i++) begin
            count_sum = count_sum + CntW'(valid_c[i]);
        end
    end

    assign out_valid_o = valid_c[Stages];
    assign out_o       = data_c[Stages][Width-1:0];
    assign err_o       = data_c[Stages][Width];
    assign count_o     = count_sum;

    a_out_stable_on_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i) |=> $stable(out_o));

    a_count_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_o <= CntW'(Stages));

endmodule

// File: tb/tb_prim_boolfn_pipe.sv
// Scoreboard bench: stimulus queues expected results, per-DUT monitors pop and compare.
module tb_prim_boolfn_pipe;
    import prim_boolfn_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: Width=32, Stages=2
    logic        rst_na, flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, err_a;
    logic [1:0]  mode_a;
    logic [31:0] x_a, y_a, z_a, out_a;
    logic [1:0]  count_a;

    // DUT B: Width=64, Stages=1
    logic        rst_nb, flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, err_b;
    logic [1:0]  mode_b;
    logic [63:0] x_b, y_b, z_b, out_b;
    logic [0:0]  count_b;

    prim_boolfn_pipe #(.Width(32), .Stages(2)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_na), .flush_i(flush_a),
        .in_valid_i(in_valid_a), .in_ready_o(in_ready_a), .mode_i(mode_a),
        .x_i(x_a), .y_i(y_a), .z_i(z_a),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready_a),
        .out_o(out_a), .err_o(err_a), .count_o(count_a)
    );

    prim_boolfn_pipe #(.Width(64), .Stages(1)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_nb), .flush_i(flush_b),
        .in_valid_i(in_valid_b), .in_ready_o(in_ready_b), .mode_i(mode_b),
        .x_i(x_b), .y_i(y_b), .z_i(z_b),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready_b),
        .out_o(out_b), .err_o(err_b), .count_o(count_b)
    );

    int errors = 0;
    int checks = 0;
    int xfer_a = 0;
    int xfer_b = 0;
    logic [32:0] q_a[$];
    logic [64:0] q_b[$];

    localparam logic [31:0] X0 = 32'hFFFF0000;
    localparam logic [31:0] Y0 = 32'hFF00FF00;
    localparam logic [31:0] Z0 = 32'hF0F0F0F0;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: a transfer happens at the next rising edge when valid & ready at the falling edge.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_na && out_valid_a && out_ready_a) begin
            xfer_a++;
            $display("a: out=%h err=%b count=%0d", out_a, err_a, count_a);
            if (q_a.size() == 0) begin
                chk("a_unexpected_output", 65'(out_valid_a), 65'd0);
            end else begin
                e = q_a.pop_front();
                chk("a_out", 65'(out_a), 65'(e[31:0]));
                chk("a_err", 65'(err_a), 65'(e[32]));
            end
        end
    end

    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_nb && out_valid_b && out_ready_b) begin
            xfer_b++;
            $display("b: out=%h err=%b count=%0d", out_b, err_b, count_b);
            if (q_b.size() == 0) begin
                chk("b_unexpected_output", 65'(out_valid_b), 65'd0);
            end else begin
                e = q_b.pop_front();
                chk("b_out", 65'(out_b), 65'(e[63:0]));
                chk("b_err", 65'(err_b), 65'(e[64]));
            end
        end
    end

    task automatic send_a(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, input logic [31:0] e, input logic ee);
        int n = 0;
        mode_a = m; x_a = x; y_a = y; z_a = z; in_valid_a = 1'b1;
        @(negedge clk);
        while (!in_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_a) chk("a_send_timeout", 65'(in_ready_a), 65'd1);
        else q_a.push_back({ee, e});
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] m, input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] z, input logic [63:0] e, input logic ee);
        int n = 0;
        mode_b = m; x_b = x; y_b = y; z_b = z; in_valid_b = 1'b1;
        @(negedge clk);
        while (!in_ready_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_b) chk("b_send_timeout", 65'(in_ready_b), 65'd1);
        else q_b.push_back({ee, e});
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        while (q_a.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("a_drain_empty", 65'(q_a.size()), 65'd0);
    endtask

    task automatic drain_b();
        int n = 0;
        while (q_b.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("b_drain_empty", 65'(q_b.size()), 65'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_na = 1'b0; flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
        mode_a = 2'b00; x_a = '0; y_a = '0; z_a = '0;
        rst_nb = 1'b0; flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1;
        mode_b = 2'b00; x_b = '0; y_b = '0; z_b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_na = 1'b1;
        rst_nb = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 65'(out_valid_a), 65'd0);
        chk("rst_out", 65'(out_a), 65'd0);
        chk("rst_err", 65'(err_a), 65'd0);
        chk("rst_count", 65'(count_a), 65'd0);
        chk("rst_in_ready", 65'(in_ready_a), 65'd1);
        @(posedge clk); #1;

        // MAJ with 2-cycle latency
        send_a(MAJ, X0, Y0, Z0, 32'hFFF0F000, 1'b0);
        @(negedge clk);
        chk("lat_not_early", 65'(out_valid_a), 65'd0);
        @(negedge clk);
        chk("lat_two_cycles", 65'(out_valid_a), 65'd1);
        drain_a();

        // Back-to-back burst, one result per cycle
        @(posedge clk); #1;
        base = xfer_a;
        send_a(PARITY, X0, Y0, Z0, 32'hF00F0FF0, 1'b0);
        send_a(CH, X0, Y0, Z0, 32'hFF00F0F0, 1'b0);
        send_a(MAJ, 32'h12345678, 32'h12345678, 32'h0F0F0F0F, 32'h12345678, 1'b0);
        send_a(PARITY, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h0000FFFF, 32'h0000FFFF, 1'b0);
        send_a(CH, 32'h00000000, 32'hDEADBEEF, 32'hCAFEBABE, 32'hCAFEBABE, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        chk("burst_throughput", 65'(xfer_a - base), 65'd5);
        drain_a();

        // Stall: two accepted, third refused, output held
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        send_a(MAJ, X0, Y0, Z0, 32'hFFF0F000, 1'b0);
        send_a(PARITY, X0, Y0, Z0, 32'hF00F0FF0, 1'b0);
        mode_a = CH; in_valid_a = 1'b1;
        @(negedge clk);
        chk("stall_in_ready", 65'(in_ready_a), 65'd0);
        chk("stall_count", 65'(count_a), 65'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_out_held", 65'(out_a), 65'h0FFF0F000);
        chk("stall_valid_held", 65'(out_valid_a), 65'd1);
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        @(negedge clk);
        chk("drain_count2", 65'(count_a), 65'd2);
        @(negedge clk);
        chk("drain_count1", 65'(count_a), 65'd1);
        @(negedge clk);
        chk("drain_count0", 65'(count_a), 65'd0);
        drain_a();

        // Reserved mode then a clean MAJ
        @(posedge clk); #1;
        send_a(2'b11, X0, Y0, Z0, 32'h00000000, 1'b1);
        send_a(MAJ, X0, Y0, Z0, 32'hFFF0F000, 1'b0);
        drain_a();

        // Flush a full pipe with input offered
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        send_a(MAJ, X0, Y0, Z0, 32'hFFF0F000, 1'b0);
        send_a(CH, X0, Y0, Z0, 32'hFF00F0F0, 1'b0);
        flush_a = 1'b1;
        in_valid_a = 1'b1;
        mode_a = PARITY;
        @(negedge clk);
        chk("flush_no_accept", 65'(in_ready_a), 65'd0);
        @(posedge clk); #1;
        flush_a = 1'b0;
        in_valid_a = 1'b0;
        q_a.delete();
        chk("flush_count", 65'(count_a), 65'd0);
        chk("flush_out_valid", 65'(out_valid_a), 65'd0);
        base = xfer_a;
        out_ready_a = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("flush_no_stale", 65'(xfer_a - base), 65'd0);

        // DUT B: async reset mid-stream, then all-ones MAJ with 1-cycle latency
        @(posedge clk); #1;
        send_b(PARITY, ONES, 64'd0, 64'd0, ONES, 1'b0);
        send_b(MAJ, 64'hAAAA_5555_AAAA_5555, 64'hAAAA_5555_AAAA_5555, 64'd0,
               64'hAAAA_5555_AAAA_5555, 1'b0);
        #2;
        chk("b_pre_reset_valid", 65'(out_valid_b), 65'd1);
        rst_nb = 1'b0;
        #1;
        q_b.delete();
        chk("b_async_valid", 65'(out_valid_b), 65'd0);
        chk("b_async_out", 65'(out_b), 65'd0);
        chk("b_async_err", 65'(err_b), 65'd0);
        chk("b_async_count", 65'(count_b), 65'd0);
        @(posedge clk); #1;
        rst_nb = 1'b1;
        @(posedge clk); #1;
        send_b(MAJ, ONES, ONES, ONES, ONES, 1'b0);
        @(negedge clk);
        chk("b_lat_one", 65'(out_valid_b), 65'd1);
        drain_b();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
